pxs_cursor_ctrl: RTL and testbench
==================================

// Module: pxs_cursor_ctrl
// PURPOSE
// - Text-console cursor/character controller: accepts a byte stream of characters, writes printable
//   ones into text video memory and drives cursor_x/cursor_y/tcursor for the cursor overlay stage.
// - Producer side of the cursor interface. Taps the Pxs RGB stream (`XC/`YC, from Pxs.vh) only for
//   frame timing, used by the cursor blink.
// PARAMETERS
// - COLS          80   text columns (<=127)
// - ROWS          60   text rows (<=127)
// - BLINK_FRAMES  30   frames per blink half-period (>=1)
// PORTS
// - px_clk      in   1   pixel clock; the only clock
// - reset       in   1   synchronous, active-high reset
// - RGBStr_i    in   26  Pxs RGB stream; only `XC/`YC are used
// - char_valid  in   1   character byte offered
// - char_data   in   8   character byte
// - char_ready  out  1   controller can accept a byte this cycle
// - wr_en       out  1   text-RAM write strobe, 1-cycle pulse
// - wr_addr     out  13  text-RAM address = row*COLS + col
// - wr_data     out  8   text-RAM data
// - cursor_x    out  7   cursor column, 0..COLS-1
// - cursor_y    out  7   cursor row, 0..ROWS-1
// - tcursor     out  4   [0] blink phase (1=visible), [1] enable, [3:2] = 0
// BEHAVIOUR
// - Reset values: cursor_x=0, cursor_y=0, tcursor=4'b0011, wr_en=0, wr_addr=0, wr_data=0,
//   char_ready=1, state=IDLE, blink frame counter=0.
// - All outputs are registered.
// - States:
//   - IDLE: char_ready=1.
//   - CLR_ROW, CLR_ALL: char_ready=0; tcursor[1]=0 (cursor hidden while clearing).
// - Handshake: a byte is accepted when char_valid && char_ready. At most one byte per cycle.
//   char_data is ignored when no byte is accepted.
// - Byte decode on accept:
//   - 0x20..0x7E (printable):
//     - next cycle: wr_en=1, wr_addr=y*COLS+x, wr_data=byte.
//     - cursor advances: x+1; if x==COLS-1 then x=0 and NEWLINE.
//   - 0x0D (CR): x=0; no write.
//   - 0x0A (LF): NEWLINE; x is unchanged.
//   - 0x08 (BS): x=x-1 if x>0, else no change; no erase; no row change.
//   - 0x0C (FF): x=0, y=0, then enter CLR_ALL.
//   - Any other byte: accepted and discarded; no state change.
// - NEWLINE:
//   - y = (y==ROWS-1) ? 0 : y+1. Wrap only; there is no scrolling.
//   - Then enter CLR_ROW for the new row y.
// - CLR_ROW: writes 0x20 to (y,0)..(y,COLS-1), one write per cycle (COLS cycles), then returns to IDLE.
//   - A printable that wraps emits its own write first. The clear writes follow back-to-back.
// - CLR_ALL: writes 0x20 to addresses 0..COLS*ROWS-1, one per cycle, then returns to IDLE.
// - Latency: cursor_x/cursor_y update 1 cycle after accept; wr_* are valid 1 cycle after accept or
//   after the clear-counter step.
// - Blink:
//   - Frame tick = first cycle with `XC==0 && `YC==0 (rising edge of that condition, registered).
//   - The counter counts ticks; at BLINK_FRAMES-1 it clears and tcursor[0] toggles.
//   - Any accepted byte forces tcursor[0]=1 and clears the counter.
//   - Ticks are counted in every state.
// - Reset asserted mid-clear: aborts the clear immediately. The next cycle has reset values and wr_en=0.
// - Arithmetic: wr_addr is computed unsigned in 13 bits. COLS*ROWS must be <= 8192.
// TESTING
// - "AB" after reset -> writes (addr0,0x41),(addr1,0x42); cursor_x=2, cursor_y=0; char_ready stays 1.
// - Start at x=79,y=3; send 0x5A -> write addr 319=0x5A; then 80 writes of 0x20 at addr 320..399;
//   char_ready=0 for 80 cycles; final cursor (0,4).
// - Start at y=59; send LF -> cursor_y=0; clears addr 0..79; cursor_x is unchanged.
// - Send BS at x=0 -> no change. Send CR at x=37 -> x=0. Neither emits wr_en.
// - Send FF -> 4800 writes of 0x20 at addr 0..4799, then char_ready=1, cursor (0,0);
//   reset asserted at write 100 -> wr_en=0 next cycle and all outputs at reset values.
// - Free-running frames, BLINK_FRAMES=2 -> tcursor[0] toggles every 2 frame ticks;
//   a byte accepted mid-phase forces tcursor[0]=1 and restarts the count.

Source files
------------

// File: rtl/pxs_cursor_ctrl.sv
// rtl/pxs_cursor_ctrl.sv - text-console cursor/character controller
//
// Accepts a byte stream of characters, writes printable ones into text video
// memory, handles CR/LF/BS/FF, clears rows/screen, and drives the cursor
// position plus blink/enable flags for the cursor overlay stage.
//
// Ports:
//   px_clk      in   pixel clock, the only clock
//   reset       in   synchronous active-high reset
//   RGBStr_i    in   Pxs RGB stream; only XC/YC are used (frame timing)
//   char_valid  in   character byte offered
//   char_data   in   character byte
//   char_ready  out  a byte can be accepted this cycle
//   wr_en       out  text-RAM write strobe (1-cycle pulse)
//   wr_addr     out  text-RAM address = row*COLS + col
//   wr_data     out  text-RAM data
//   cursor_x    out  cursor column
//   cursor_y    out  cursor row
//   tcursor     out  [0] blink phase (1=visible), [1] enable, [3:2] zero
module pxs_cursor_ctrl #(
  parameter int COLS         = 80,
  parameter int ROWS         = 60,
  parameter int BLINK_FRAMES = 30
) (
  input  logic        px_clk,
  input  logic        reset,
  input  logic [25:0] RGBStr_i,
  input  logic        char_valid,
  input  logic [7:0]  char_data,
  output logic        char_ready,
  output logic        wr_en,
  output logic [12:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic [6:0]  cursor_x,
  output logic [6:0]  cursor_y,
  output logic [3:0]  tcursor
);

  // Pxs stream layout: {colour[5:0], XC[9:0], YC[9:0]}
  localparam int XC_LSB = 10;
  localparam int YC_LSB = 0;
  localparam int TOTAL  = COLS * ROWS;
  localparam int BW     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef enum logic [1:0] {IDLE, CLR_ROW, CLR_ALL} state_t;

  state_t        state;
  logic [12:0]   clr_addr;
  logic [12:0]   clr_end;
  logic          blink_on;
  logic          cur_en;
  logic [BW-1:0] blink_cnt;
  logic          frame_q;
  logic          frame_tick;

  logic [9:0]    xc;
  logic [9:0]    yc;
  logic          frame_cond;
  logic          unused_rgb;

  assign xc         = RGBStr_i[XC_LSB +: 10];
  assign yc         = RGBStr_i[YC_LSB +: 10];
  assign frame_cond = (xc == 10'd0) && (yc == 10'd0);
  assign unused_rgb = ^RGBStr_i[25:20];

  assign tcursor = {2'b00, cur_en, blink_on};

  logic        accept;
  logic        is_print;
  logic        x_last;
  logic [6:0]  y_next;
  logic [12:0] cur_addr;
  logic [12:0] next_row_base;
  logic        start_row;

  always_comb begin
    accept        = char_valid && char_ready;
    is_print      = (char_data >= 8'h20) && (char_data <= 8'h7E);
    x_last        = (cursor_x == 7'(COLS - 1));
    y_next        = (cursor_y == 7'(ROWS - 1)) ? 7'd0 : cursor_y + 7'd1;
    cur_addr      = 13'(cursor_y) * 13'(COLS) + 13'(cursor_x);
    next_row_base = 13'(y_next) * 13'(COLS);
    // A newline happens on LF or on a printable in the last column.
    start_row     = accept && ((char_data == 8'h0A) || (is_print && x_last));
  end

  always_ff @(posedge px_clk) begin
    if (reset) begin
      state      <= IDLE;
      cursor_x   <= '0;
      cursor_y   <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      char_ready <= 1'b1;
      blink_on   <= 1'b1;
      cur_en     <= 1'b1;
      blink_cnt  <= '0;
      frame_q    <= 1'b0;
      frame_tick <= 1'b0;
      clr_addr   <= '0;
      clr_end    <= '0;
    end else begin
      wr_en <= 1'b0;

      // Frame tick: registered rising edge of the (0,0) pixel condition.
      frame_q    <= frame_cond;
      frame_tick <= frame_cond && !frame_q;

      // Any accepted byte makes the cursor visible and restarts the phase.
      if (accept) begin
        blink_on  <= 1'b1;
        blink_cnt <= '0;
      end else if (frame_tick) begin
        if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
          blink_cnt <= '0;
          blink_on  <= ~blink_on;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (accept) begin
            if (is_print) begin
              wr_en   <= 1'b1;
              wr_addr <= cur_addr;
              wr_data <= char_data;
              if (x_last) begin
                cursor_x <= '0;
                cursor_y <= y_next;
              end else begin
                cursor_x <= cursor_x + 7'd1;
              end
            end else begin
              case (char_data)
                8'h0D: cursor_x <= '0;
                8'h0A: cursor_y <= y_next;
                8'h08: if (cursor_x != 7'd0) cursor_x <= cursor_x - 7'd1;
                8'h0C: begin
                  cursor_x   <= '0;
                  cursor_y   <= '0;
                  state      <= CLR_ALL;
                  clr_addr   <= '0;
                  clr_end    <= 13'(TOTAL - 1);
                  char_ready <= 1'b0;
                  cur_en     <= 1'b0;
                end
                default: ;
              endcase
            end
            if (start_row) begin
              state      <= CLR_ROW;
              clr_addr   <= next_row_base;
              clr_end    <= next_row_base + 13'(COLS - 1);
              char_ready <= 1'b0;
              cur_en     <= 1'b0;
            end
          end
        end
        CLR_ROW, CLR_ALL: begin
          wr_en    <= 1'b1;
          wr_addr  <= clr_addr;
          wr_data  <= 8'h20;
          clr_addr <= clr_addr + 13'd1;
          if (clr_addr == clr_end) begin
            state      <= IDLE;
            char_ready <= 1'b1;
            cur_en     <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pxs_cursor_ctrl.sv
// tb/tb_pxs_cursor_ctrl.sv - directed self-checking bench for pxs_cursor_ctrl
module tb_pxs_cursor_ctrl;

  logic        px_clk = 1'b0;
  logic        reset;
  logic [25:0] RGBStr_i;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_ready;
  logic        wr_en;
  logic [12:0] wr_addr;
  logic [7:0]  wr_data;
  logic [6:0]  cursor_x;
  logic [6:0]  cursor_y;
  logic [3:0]  tcursor;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  localparam logic [25:0] RGB_IDLE = 26'h400; // XC=1, YC=0: not a frame start

  pxs_cursor_ctrl #(.COLS(80), .ROWS(60), .BLINK_FRAMES(2)) dut (
    .px_clk     (px_clk),
    .reset      (reset),
    .RGBStr_i   (RGBStr_i),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_ready (char_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cursor_x   (cursor_x),
    .cursor_y   (cursor_y),
    .tcursor    (tcursor)
  );

  always #5 px_clk = ~px_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge px_clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge px_clk);
    char_valid = 1'b1;
    char_data  = b;
    @(posedge px_clk);
    #1;
    char_valid = 1'b0;
    char_data  = 8'h00;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 6000 && char_ready !== 1'b1; i++) tick();
    check(tag, char_ready, 1);
  endtask

  // Expects n consecutive space writes from start; char_ready low until the last.
  task automatic clear_check(input string tag, input int start, input int n);
    int bad = 0;
    int rbad = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (!(wr_en === 1'b1 && wr_addr === 13'(start + i) && wr_data === 8'h20)) bad++;
      if (i < n - 1 && char_ready !== 1'b0) rbad++;
    end
    check({tag, "_writes_bad"}, bad, 0);
    check({tag, "_ready_bad"}, rbad, 0);
  endtask

  task automatic frame();
    @(negedge px_clk);
    RGBStr_i = 26'h0;
    @(negedge px_clk);
    RGBStr_i = RGB_IDLE;
    repeat (3) @(posedge px_clk);
    #1;
  endtask

  initial begin
    reset      = 1'b1;
    RGBStr_i   = RGB_IDLE;
    char_valid = 1'b0;
    char_data  = 8'h00;
    repeat (3) tick();

    // Reset state
    check("rst_x", cursor_x, 0);
    check("rst_y", cursor_y, 0);
    check("rst_tcursor", tcursor, 4'b0011);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_ready", char_ready, 1);
    @(negedge px_clk);
    reset = 1'b0;

    // "AB"
    send(8'h41);
    check("A_wr_en", wr_en, 1);
    check("A_addr", wr_addr, 0);
    check("A_data", wr_data, 8'h41);
    check("A_x", cursor_x, 1);
    send(8'h42);
    check("B_wr_en", wr_en, 1);
    check("B_addr", wr_addr, 1);
    check("B_data", wr_data, 8'h42);
    tick();
    check("AB_wr_idle", wr_en, 0);
    check("AB_x", cursor_x, 2);
    check("AB_y", cursor_y, 0);
    check("AB_ready", char_ready, 1);

    // BS / CR / discarded control byte
    send(8'h08);
    check("bs_x", cursor_x, 1);
    check("bs_wr", wr_en, 0);
    send(8'h0D);
    check("cr_x", cursor_x, 0);
    send(8'h08);
    check("bs0_x", cursor_x, 0);
    check("bs0_wr", wr_en, 0);
    for (int i = 0; i < 37; i++) send(8'h2E);
    check("dots_x", cursor_x, 37);
    send(8'h0D);
    check("cr37_x", cursor_x, 0);
    check("cr37_wr", wr_en, 0);
    send(8'h01);
    check("other_x", cursor_x, 0);
    check("other_y", cursor_y, 0);
    check("other_wr", wr_en, 0);
    check("other_ready", char_ready, 1);

    // First LF: row 1 cleared at 80..159
    send(8'h0A);
    check("lf1_y", cursor_y, 1);
    check("lf1_ready", char_ready, 0);
    check("lf1_en", tcursor[1], 0);
    clear_check("lf1_clr", 80, 80);
    send(8'h0A);
    wait_idle("lf2_idle");
    send(8'h0A);
    wait_idle("lf3_idle");
    check("row3_y", cursor_y, 3);

    // Wrap from (79,3)
    for (int i = 0; i < 79; i++) send(8'h61);
    check("pre_wrap_x", cursor_x, 79);
    send(8'h5A);
    check("wrap_wr_en", wr_en, 1);
    check("wrap_addr", wr_addr, 319);
    check("wrap_data", wr_data, 8'h5A);
    check("wrap_ready", char_ready, 0);
    clear_check("wrap_clr", 320, 80);
    check("wrap_ready_back", char_ready, 1);
    check("wrap_en_back", tcursor[1], 1);
    check("wrap_x", cursor_x, 0);
    check("wrap_y", cursor_y, 4);
    tick();
    check("wrap_wr_done", wr_en, 0);

    // LF wrap from row 59 with x=2
    send(8'h71);
    send(8'h72);
    for (int i = 0; i < 55; i++) begin
      send(8'h0A);
      wait_idle("lf_chain_idle");
    end
    check("row59_y", cursor_y, 59);
    send(8'h0A);
    check("lfw_y", cursor_y, 0);
    check("lfw_x", cursor_x, 2);
    check("lfw_wr", wr_en, 0);
    clear_check("lfw_clr", 0, 80);
    check("lfw_x_after", cursor_x, 2);

    // Form feed: full clear
    send(8'h0C);
    check("ff_x", cursor_x, 0);
    check("ff_y", cursor_y, 0);
    check("ff_tcursor", tcursor, 4'b0001);
    check("ff_ready", char_ready, 0);
    check("ff_wr", wr_en, 0);
    clear_check("ff_clr", 0, 4800);
    check("ff_ready_back", char_ready, 1);
    check("ff_tcursor_back", tcursor, 4'b0011);
    tick();
    check("ff_wr_done", wr_en, 0);

    // Form feed aborted by reset after 100 writes
    send(8'h41);
    send(8'h0C);
    clear_check("ffa_clr", 0, 100);
    @(negedge px_clk);
    reset = 1'b1;
    tick();
    check("abort_wr_en", wr_en, 0);
    check("abort_addr", wr_addr, 0);
    check("abort_data", wr_data, 0);
    check("abort_ready", char_ready, 1);
    check("abort_tcursor", tcursor, 4'b0011);
    check("abort_x", cursor_x, 0);
    check("abort_y", cursor_y, 0);
    @(negedge px_clk);
    reset = 1'b0;
    tick();
    check("abort_stays_idle", wr_en, 0);

    // Blink with BLINK_FRAMES=2
    frame();
    check("blink_f1", tcursor[0], 1);
    frame();
    check("blink_f2", tcursor[0], 0);
    frame();
    check("blink_f3", tcursor[0], 0);
    send(8'h01);
    check("blink_force", tcursor, 4'b0011);
    frame();
    check("blink_f4", tcursor[0], 1);
    frame();
    check("blink_f5", tcursor[0], 0);
    frame();
    check("blink_f6", tcursor[0], 0);
    frame();
    check("blink_f7", tcursor[0], 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
